// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the IF/MEM SRAM-like port arbiter: FSM states,
// grant-owner codes and the SRAM-like transfer size codes.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_arbiter_if.sv
// One SRAM-like request/response channel. The requester uses the master
// modport and the responder uses the slave modport.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arbiter_arb_grant_sel.sv
// Combinational winner select between the inst and data masters.
// SRAM_ARB_RR_EN selects round-robin; otherwise data always beats inst.
module sram_arbiter_arb_grant_sel
  import sram_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last,
  output logic winner
);

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    winner = d_req ? OWN_DATA : OWN_INST;
    // On a tie, hand the port to whoever did not get it last time.
    if (i_req && d_req) winner = ~last;
  end
`else
  logic unused_sel;
  assign unused_sel = i_req ^ last;
  assign winner     = d_req ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (IF/MEM) to one-slave SRAM-like arbiter, one transaction in
// flight. Define SRAM_ARB_RR_EN for round-robin instead of data priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  i_bus,
  sram_arbiter_if.slave  d_bus,
  sram_arbiter_if.master s_bus
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              winner;
  logic              last;
  logic              owner_req;
  logic              fwd_en;
  logic              addr_hs;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_wdata;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;
  assign last = last_q;
`else
  assign last = OWN_DATA;
`endif

  sram_arbiter_arb_grant_sel u_grant_sel (
    .i_req  (i_bus.req),
    .d_req  (d_bus.req),
    .last   (last),
    .winner (winner)
  );

  assign owner_req = (owner_q == OWN_DATA) ? d_bus.req : i_bus.req;
  // A dropped owner req in ADDR stalls the slave request rather than aborting.
  assign fwd_en    = (state_q == ST_ADDR) && owner_req;
  assign addr_hs   = fwd_en && s_bus.addr_ok;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef SRAM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_bus.req || d_bus.req) begin
          state_d = ST_ADDR;
          owner_d = winner;
`ifdef SRAM_ARB_RR_EN
          last_d  = winner;
`endif
        end
      end
      ST_ADDR: if (addr_hs) state_d = ST_DATA;
      ST_DATA: if (s_bus.data_ok) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) last_q <= OWN_DATA;
    else       last_q <= last_d;
  end
`endif

  always_comb begin
    s_bus.req   = 1'b0;
    s_bus.wr    = 1'b0;
    s_bus.size  = 2'd0;
    s_bus.wstrb = 4'd0;
    fwd_addr    = '0;
    fwd_wdata   = '0;
    if (fwd_en) begin
      s_bus.req = 1'b1;
      if (owner_q == OWN_DATA) begin
        s_bus.wr    = d_bus.wr;
        s_bus.size  = d_bus.size;
        s_bus.wstrb = d_bus.wstrb;
        fwd_addr    = d_bus.addr;
        fwd_wdata   = d_bus.wdata;
      end else begin
        s_bus.wr    = i_bus.wr;
        s_bus.size  = i_bus.size;
        s_bus.wstrb = i_bus.wstrb;
        fwd_addr    = i_bus.addr;
        fwd_wdata   = i_bus.wdata;
      end
    end
  end

  assign s_bus.addr  = fwd_addr;
  assign s_bus.wdata = fwd_wdata;

  // Responses only reach the owner; stray slave strobes in other states die here.
  assign i_bus.addr_ok = addr_hs && (owner_q == OWN_INST);
  assign d_bus.addr_ok = addr_hs && (owner_q == OWN_DATA);
  assign i_bus.data_ok = (state_q == ST_DATA) && (owner_q == OWN_INST) && s_bus.data_ok;
  assign d_bus.data_ok = (state_q == ST_DATA) && (owner_q == OWN_DATA) && s_bus.data_ok;
  assign i_bus.rdata   = s_bus.rdata;
  assign d_bus.rdata   = s_bus.rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model and a behavioural SRAM-like slave.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i_if ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_if ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .i_bus (i_if),
    .d_bus (d_if),
    .s_bus (s_if)
  );

  int vectors = 0;
  int miscompares = 0;

  // behavioural slave
  int          sl_adly = 0, sl_ddly = 0, sl_acnt = 0, sl_dcnt = 0;
  bit          sl_dpend = 0, sl_rand = 0, stray_dok = 0;
  logic [31:0] sl_addr = '0;

  // reference model: the transaction currently in service
  bit svc_v = 0, svc_m = 0, svc_acc = 0, last_m = 1;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a == 32'h1c000000) ? 32'h02800000 : (a ^ 32'hffff0000);
  endfunction

  function automatic bit pick(input bit i, input bit d, input bit last);
    return (RR && i && d) ? !last : d;
  endfunction

  task automatic clear_masters();
    i_if.req = 0; i_if.wr = 0; i_if.size = 0; i_if.wstrb = 0; i_if.addr = 0; i_if.wdata = 0;
    d_if.req = 0; d_if.wr = 0; d_if.size = 0; d_if.wstrb = 0; d_if.addr = 0; d_if.wdata = 0;
  endtask

  // Let the DUT react to master inputs, then drive the slave response.
  task automatic settle();
    s_if.addr_ok = 0; s_if.data_ok = 0; s_if.rdata = '0;
    #1;
    if (sl_dpend) begin
      if (sl_dcnt >= sl_ddly) begin s_if.data_ok = 1; s_if.rdata = rdata_of(sl_addr); end
    end else if (s_if.req === 1'b1 && sl_acnt >= sl_adly) s_if.addr_ok = 1;
    if (stray_dok) begin s_if.data_ok = 1; s_if.rdata = 32'h0bad0bad; end
    #1;
  endtask

  // Advance model and slave over the next edge, then clock.
  task automatic adv();
    bit ir, dr;
    ir = i_if.req; dr = d_if.req;
    if (reset) begin
      svc_v = 0; svc_m = 0; svc_acc = 0; last_m = 1;
    end else if (!svc_v) begin
      if (ir || dr) begin svc_v = 1; svc_acc = 0; svc_m = pick(ir, dr, last_m); last_m = svc_m; end
    end else if (!svc_acc) begin
      if ((svc_m ? dr : ir) && s_if.addr_ok) svc_acc = 1;
    end else if (s_if.data_ok) svc_v = 0;

    if (reset) begin
      sl_dpend = 0; sl_acnt = 0; sl_dcnt = 0;
    end else if (sl_dpend) begin
      if (s_if.data_ok) begin
        sl_dpend = 0;
        if (sl_rand) begin sl_adly = $urandom_range(0, 2); sl_ddly = $urandom_range(0, 3); end
      end else sl_dcnt++;
    end else if (s_if.req === 1'b1) begin
      if (s_if.addr_ok) begin sl_dpend = 1; sl_dcnt = 0; sl_acnt = 0; sl_addr = s_if.addr; end
      else sl_acnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; stray_dok = 0; sl_adly = 0; sl_ddly = 0; sl_rand = 0;
    clear_masters();
    settle(); adv(); adv();
    reset = 0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({s_if.req, i_if.addr_ok, i_if.data_ok, d_if.addr_ok, d_if.data_ok} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 00000", {s_if.req, i_if.addr_ok, i_if.data_ok, d_if.addr_ok, d_if.data_ok});
    end
    vectors++;
    if (s_if.addr !== 32'h0 || s_if.wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr_wdata: got %h/%h want 0/0", s_if.addr, s_if.wdata);
    end
    vectors++;
    if ({s_if.wstrb, s_if.size, s_if.wr} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {s_if.wstrb, s_if.size, s_if.wr});
    end
  endtask

  task automatic test_single_inst_read();
    do_reset();
    i_if.req = 1; i_if.wr = 0; i_if.size = 2; i_if.addr = 32'h1c000000;
    settle();
    vectors++;
    if (s_if.req !== 1'b0) begin miscompares++; $display("FAIL single_sreq_early: got %b want 0", s_if.req); end
    adv(); settle();
    vectors++;
    if ({s_if.req, i_if.addr_ok} !== 2'b11 || s_if.addr !== 32'h1c000000) begin
      miscompares++;
      $display("FAIL single_addr_phase: got req/aok %b addr %h want 11 1c000000", {s_if.req, i_if.addr_ok}, s_if.addr);
    end
    vectors++;
    if ({i_if.data_ok, d_if.addr_ok, d_if.data_ok} !== 3'b0) begin
      miscompares++;
      $display("FAIL single_addr_others: got %b want 000", {i_if.data_ok, d_if.addr_ok, d_if.data_ok});
    end
    adv(); i_if.req = 0; settle();
    vectors++;
    if ({i_if.data_ok, i_if.addr_ok, d_if.data_ok} !== 3'b100 || i_if.rdata !== 32'h02800000) begin
      miscompares++;
      $display("FAIL single_data_phase: got %b rdata %h want 100 02800000", {i_if.data_ok, i_if.addr_ok, d_if.data_ok}, i_if.rdata);
    end
    adv(); settle();
    vectors++;
    if ({s_if.req, i_if.data_ok, d_if.addr_ok, d_if.data_ok} !== 4'b0) begin
      miscompares++;
      $display("FAIL single_after: got %b want 0000", {s_if.req, i_if.data_ok, d_if.addr_ok, d_if.data_ok});
    end
  endtask

  task automatic test_simultaneous();
    bit first;
    logic [31:0] fa, sa, fw;
    do_reset();
    i_if.req = 1; i_if.wr = 0; i_if.size = 2; i_if.addr = 32'h1c000040;
    d_if.req = 1; d_if.wr = 1; d_if.size = 2; d_if.wstrb = 4'hf; d_if.addr = 32'h1c001000; d_if.wdata = 32'hdeadbeef;
    settle(); adv(); settle();
    first = svc_m;
    fa = first ? 32'h1c001000 : 32'h1c000040;
    sa = first ? 32'h1c000040 : 32'h1c001000;
    fw = first ? 32'hdeadbeef : 32'h0;
    vectors++;
    if (s_if.req !== 1'b1 || s_if.addr !== fa || s_if.wr !== first || s_if.wdata !== fw) begin
      miscompares++;
      $display("FAIL simul_first: got req %b addr %h wr %b wdata %h want 1 %h %b %h", s_if.req, s_if.addr, s_if.wr, s_if.wdata, fa, first, fw);
    end
    vectors++;
    if ({d_if.addr_ok, i_if.addr_ok} !== (first ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL simul_first_aok: got %b want %b", {d_if.addr_ok, i_if.addr_ok}, first ? 2'b10 : 2'b01);
    end
    adv();
    if (first) d_if.req = 0; else i_if.req = 0;
    settle();
    vectors++;
    if ({d_if.data_ok, i_if.data_ok, d_if.addr_ok, i_if.addr_ok} !== (first ? 4'b1000 : 4'b0100)) begin
      miscompares++;
      $display("FAIL simul_first_dok: got %b want %b", {d_if.data_ok, i_if.data_ok, d_if.addr_ok, i_if.addr_ok}, first ? 4'b1000 : 4'b0100);
    end
    adv(); settle();
    vectors++;
    if (s_if.req !== 1'b0) begin miscompares++; $display("FAIL simul_gap_idle: got %b want 0", s_if.req); end
    adv(); settle();
    vectors++;
    if (s_if.req !== 1'b1 || s_if.addr !== sa || {d_if.addr_ok, i_if.addr_ok} !== (first ? 2'b01 : 2'b10)) begin
      miscompares++;
      $display("FAIL simul_second: got req %b addr %h aok %b want 1 %h", s_if.req, s_if.addr, {d_if.addr_ok, i_if.addr_ok}, sa);
    end
    adv(); clear_masters(); settle();
    vectors++;
    if ({d_if.data_ok, i_if.data_ok} !== (first ? 2'b01 : 2'b10) || s_if.rdata !== rdata_of(sa)) begin
      miscompares++;
      $display("FAIL simul_second_dok: got %b rdata %h want %b %h", {d_if.data_ok, i_if.data_ok}, s_if.rdata, first ? 2'b01 : 2'b10, rdata_of(sa));
    end
  endtask

  task automatic test_wait_slave();
    int sreq_n, aok_n, dok_n, unstable, overlap, dok_at;
    bit drop;
    sreq_n = 0; aok_n = 0; dok_n = 0; unstable = 0; overlap = 0; dok_at = -1;
    do_reset();
    sl_adly = 3; sl_ddly = 5;
    i_if.req = 1; i_if.wr = 0; i_if.size = 2; i_if.addr = 32'h1c000100;
    settle(); adv();
    for (int c = 0; c < 14; c++) begin
      settle();
      if (s_if.req === 1'b1) begin
        sreq_n++;
        if (s_if.addr !== 32'h1c000100 || s_if.wr !== 1'b0 || s_if.size !== 2'd2) unstable++;
      end
      if (i_if.addr_ok) aok_n++;
      if (i_if.data_ok) begin dok_n++; dok_at = c; end
      if ((i_if.addr_ok && i_if.data_ok) || d_if.addr_ok || d_if.data_ok) overlap++;
      drop = i_if.addr_ok;
      adv();
      if (drop) i_if.req = 0;
    end
    vectors++;
    if (unstable !== 0 || sreq_n !== 4) begin
      miscompares++;
      $display("FAIL wait_addr_phase: got unstable %0d sreq cycles %0d want 0 4", unstable, sreq_n);
    end
    vectors++;
    if (aok_n !== 1 || dok_n !== 1 || overlap !== 0) begin
      miscompares++;
      $display("FAIL wait_pulses: got aok %0d dok %0d overlap %0d want 1 1 0", aok_n, dok_n, overlap);
    end
    vectors++;
    if (dok_at !== 9) begin miscompares++; $display("FAIL wait_dok_cycle: got %0d want 9", dok_at); end
  endtask

  task automatic test_reset_in_data();
    do_reset();
    sl_ddly = 4;
    i_if.req = 1; i_if.size = 2; i_if.addr = 32'h1c000200;
    settle(); adv(); settle(); adv();
    i_if.req = 0; settle(); adv(); settle();
    reset = 1; settle(); adv();
    reset = 0; settle();
    vectors++;
    if ({s_if.req, i_if.addr_ok, i_if.data_ok, d_if.addr_ok, d_if.data_ok} !== 5'b0 ||
        {s_if.addr, s_if.wdata, s_if.wstrb, s_if.size, s_if.wr} !== 71'b0) begin
      miscompares++;
      $display("FAIL rst_data_outputs: got strobes %b addr %h want all 0",
               {s_if.req, i_if.addr_ok, i_if.data_ok, d_if.addr_ok, d_if.data_ok}, s_if.addr);
    end
    stray_dok = 1; settle();
    vectors++;
    if ({i_if.data_ok, d_if.data_ok} !== 2'b0) begin
      miscompares++;
      $display("FAIL rst_late_dok: got %b want 00", {i_if.data_ok, d_if.data_ok});
    end
    adv(); stray_dok = 0; settle();
    vectors++;
    if ({s_if.req, i_if.data_ok, d_if.data_ok} !== 3'b0) begin
      miscompares++;
      $display("FAIL rst_after_late: got %b want 000", {s_if.req, i_if.data_ok, d_if.data_ok});
    end
  endtask

  task automatic test_stray();
    do_reset();
    stray_dok = 1; settle();
    vectors++;
    if ({i_if.data_ok, d_if.data_ok} !== 2'b0) begin
      miscompares++;
      $display("FAIL stray_dok: got %b want 00", {i_if.data_ok, d_if.data_ok});
    end
    adv(); stray_dok = 0;
    d_if.req = 1; d_if.size = 2; d_if.addr = 32'h1c002000; settle();
    vectors++;
    if (s_if.req !== 1'b0) begin miscompares++; $display("FAIL stray_idle: got %b want 0", s_if.req); end
    adv(); settle();
    vectors++;
    if ({s_if.req, d_if.addr_ok} !== 2'b11 || s_if.addr !== 32'h1c002000) begin
      miscompares++;
      $display("FAIL stray_next_addr: got %b addr %h want 11 1c002000", {s_if.req, d_if.addr_ok}, s_if.addr);
    end
    adv(); clear_masters(); settle();
    vectors++;
    if (d_if.data_ok !== 1'b1 || d_if.rdata !== rdata_of(32'h1c002000)) begin
      miscompares++;
      $display("FAIL stray_next_data: got %b %h want 1 %h", d_if.data_ok, d_if.rdata, rdata_of(32'h1c002000));
    end
  endtask

  task automatic test_back_to_back();
    bit obs[4], exp_g[4];
    int at[4];
    int n, c, bad_gap;
    bit prev;
    n = 0; c = 0; bad_gap = 0;
    do_reset();
    prev = last_m;
    for (int k = 0; k < 4; k++) begin exp_g[k] = pick(1'b1, 1'b1, prev); prev = exp_g[k]; end
    i_if.req = 1; i_if.size = 2; i_if.addr = 32'h1c000300;
    d_if.req = 1; d_if.size = 2; d_if.addr = 32'h1c003000;
    settle();
    while (c < 40 && n < 4) begin
      if (s_if.req === 1'b1 && s_if.addr_ok) begin
        obs[n] = (s_if.addr == 32'h1c003000);
        at[n] = c;
        n++;
      end
      adv(); settle();
      c++;
    end
    clear_masters(); settle(); adv(); settle();
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d grants want 4", n);
    end else begin
      for (int k = 1; k < 4; k++) if (at[k] - at[k-1] != 3) bad_gap++;
      vectors++;
      if ({obs[0], obs[1], obs[2], obs[3]} !== {exp_g[0], exp_g[1], exp_g[2], exp_g[3]}) begin
        miscompares++;
        $display("FAIL b2b_order: got %b want %b", {obs[0], obs[1], obs[2], obs[3]}, {exp_g[0], exp_g[1], exp_g[2], exp_g[3]});
      end
      vectors++;
      if (bad_gap !== 0) begin
        miscompares++;
        $display("FAIL b2b_gap: got %0d bad gaps (first grants at %0d,%0d) want 0", bad_gap, at[0], at[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [71:0] act_f, exp_f;
    logic [3:0]  act_h, exp_h;
    logic [31:0] acc_addr[2];
    bit wresp[2];
    bit exp_sreq, i_aok, d_aok, i_dok, d_dok;
    do_reset();
    sl_rand = 1; sl_adly = 1; sl_ddly = 2;
    wresp[0] = 0; wresp[1] = 0; acc_addr[0] = '0; acc_addr[1] = '0;
    for (int c = 0; c < 400; c++) begin
      settle();
      exp_sreq = svc_v && !svc_acc && (svc_m ? d_if.req : i_if.req);
      exp_f = '0;
      if (exp_sreq)
        exp_f = svc_m ? {1'b1, d_if.wr, d_if.size, d_if.wstrb, d_if.addr, d_if.wdata}
                      : {1'b1, i_if.wr, i_if.size, i_if.wstrb, i_if.addr, i_if.wdata};
      act_f = {s_if.req, s_if.wr, s_if.size, s_if.wstrb, s_if.addr, s_if.wdata};
      exp_h = {exp_sreq && !svc_m && s_if.addr_ok, exp_sreq && svc_m && s_if.addr_ok,
               svc_v && svc_acc && !svc_m && s_if.data_ok, svc_v && svc_acc && svc_m && s_if.data_ok};
      act_h = {i_if.addr_ok, d_if.addr_ok, i_if.data_ok, d_if.data_ok};
      vectors++;
      if (act_f !== exp_f) begin
        miscompares++;
        $display("FAIL rand_fwd c%0d: got %h want %h", c, act_f, exp_f);
      end
      vectors++;
      if (act_h !== exp_h) begin
        miscompares++;
        $display("FAIL rand_hs c%0d: got %b want %b", c, act_h, exp_h);
      end
      if (i_if.data_ok === 1'b1) begin
        vectors++;
        if (i_if.rdata !== rdata_of(acc_addr[0])) begin
          miscompares++;
          $display("FAIL rand_irdata c%0d: got %h want %h", c, i_if.rdata, rdata_of(acc_addr[0]));
        end
      end
      if (d_if.data_ok === 1'b1) begin
        vectors++;
        if (d_if.rdata !== rdata_of(acc_addr[1])) begin
          miscompares++;
          $display("FAIL rand_drdata c%0d: got %h want %h", c, d_if.rdata, rdata_of(acc_addr[1]));
        end
      end
      i_aok = i_if.addr_ok; d_aok = d_if.addr_ok; i_dok = i_if.data_ok; d_dok = d_if.data_ok;
      adv();
      if (i_if.req && i_aok) begin i_if.req = 0; wresp[0] = 1; acc_addr[0] = i_if.addr; end
      if (wresp[0] && i_dok) wresp[0] = 0;
      if (!i_if.req && !wresp[0] && $urandom_range(0, 2) == 0) begin
        i_if.req = 1; i_if.wr = 1'($urandom); i_if.size = 2'($urandom_range(0, 2));
        i_if.wstrb = 4'($urandom); i_if.addr = $urandom & 32'hfffffffc; i_if.wdata = $urandom;
      end
      if (d_if.req && d_aok) begin d_if.req = 0; wresp[1] = 1; acc_addr[1] = d_if.addr; end
      if (wresp[1] && d_dok) wresp[1] = 0;
      if (!d_if.req && !wresp[1] && $urandom_range(0, 2) == 0) begin
        d_if.req = 1; d_if.wr = 1'($urandom); d_if.size = 2'($urandom_range(0, 2));
        d_if.wstrb = 4'($urandom); d_if.addr = $urandom & 32'hfffffffc; d_if.wdata = $urandom;
      end
    end
    sl_rand = 0;
  endtask

  initial begin
    reset = 1;
    clear_masters();
    test_reset();
    test_single_inst_read();
    test_simultaneous();
    test_wait_slave();
    test_reset_in_data();
    test_stray();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
